// File: rtl/arm_rf_pkg.sv
// Shared constants and types for the ARM multi-ported register bank.
// Default widths, PC alias index and CPSR flag bit positions.
package arm_rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_AW       = $clog2(RF_NUM_REGS);
  localparam int RF_PC_IDX   = 15;
  localparam int RF_PC_STEP  = 4;

  // CPSR flags live in the top byte for a 32-bit CPSR
  localparam int CPSR_FLAG_BYTE = 3;
  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  typedef logic [RF_DATA_W-1:0] word_t;
endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register bank.
// Optional write-first forwarding when RF_BYPASS_EN is defined.
module rf_read_port
  import arm_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int NUM_WR   = 2,
  parameter int PC_IDX   = RF_PC_IDX
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [AW-1:0]                    rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]    wr_data,
  input  logic                             pc_we,
  input  logic [DATA_W-1:0]                pc_wdata,
  output logic [DATA_W-1:0]                rd_data
);
  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

  logic              addr_ok;
  logic [DATA_W-1:0] sel;

  assign addr_ok = {1'b0, rd_addr} < NREGS;

`ifdef RF_BYPASS_EN
  // Ascending scan so the last match is the highest-priority writer
  always_comb begin
    sel = '0;
    if (addr_ok) begin
      sel = regs[rd_addr];
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && wr_addr[j] == rd_addr) sel = wr_data[j];
      if (pc_we && rd_addr == AW'(PC_IDX)) sel = pc_wdata;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{wr_en, wr_addr, wr_data, pc_we, pc_wdata};

  always_comb begin
    sel = '0;
    if (addr_ok) sel = regs[rd_addr];
  end
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data <= '0;
    else        rd_data <= sel;
endmodule

// File: rtl/reg_bank_mp.sv
// Multi-ported ARM register bank: GPRs, auto-incrementing PC alias, byte-enabled CPSR.
// Define RF_BYPASS_EN for write-first read forwarding; default build reads old contents.
module reg_bank_mp
  import arm_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int PC_IDX   = RF_PC_IDX,
  parameter int PC_STEP  = RF_PC_STEP,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     pc_stall,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_wdata,
  output logic [DATA_W-1:0]        pc,
  input  logic                     cpsr_we,
  input  logic [DATA_W/8-1:0]      cpsr_be,
  input  logic [DATA_W-1:0]        cpsr_wdata,
  output logic [DATA_W-1:0]        cpsr
);
  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_RD-1:0][AW-1:0]       rd_addr_a;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_a;
  logic [NUM_WR-1:0][AW-1:0]       wr_addr_a;
  logic [NUM_WR-1:0][DATA_W-1:0]   wr_data_a;

  assign rd_addr_a = rd_addr;
  assign wr_addr_a = wr_addr;
  assign wr_data_a = wr_data;
  assign rd_data   = rd_data_a;
  assign pc        = regs[PC_IDX];

  // Later assignments override earlier ones: increment < ports (ascending) < pc_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (!pc_stall) regs[PC_IDX] <= regs[PC_IDX] + DATA_W'(PC_STEP);
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && ({1'b0, wr_addr_a[j]} < NREGS))
          regs[wr_addr_a[j]] <= wr_data_a[j];
      if (pc_we) regs[PC_IDX] <= pc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr <= '0;
    end else if (cpsr_we) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (cpsr_be[b]) cpsr[b*8 +: 8] <= cpsr_wdata[b*8 +: 8];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .AW      (AW),
      .NUM_WR  (NUM_WR),
      .PC_IDX  (PC_IDX)
    ) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (rd_addr_a[i]),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_addr (wr_addr_a),
      .wr_data (wr_data_a),
      .pc_we   (pc_we),
      .pc_wdata(pc_wdata),
      .rd_data (rd_data_a[i])
    );
  end
endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed self-checking bench for reg_bank_mp (default 16x32, 4 read / 2 write ports).
// Expected values are hand-computed; bypass-dependent ones switch on RF_BYPASS_EN.
module tb_reg_bank_mp;
  import arm_rf_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0][3:0]   rd_addr;
  logic [3:0][31:0]  rd_data;
  logic [1:0]        wr_en;
  logic [1:0][3:0]   wr_addr;
  logic [1:0][31:0]  wr_data;
  logic              pc_stall, pc_we, cpsr_we;
  logic [31:0]       pc_wdata, pc, cpsr_wdata, cpsr;
  logic [3:0]        cpsr_be;

  int checks = 0;
  int errors = 0;

  reg_bank_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_stall(pc_stall), .pc_we(pc_we), .pc_wdata(pc_wdata), .pc(pc),
    .cpsr_we(cpsr_we), .cpsr_be(cpsr_be), .cpsr_wdata(cpsr_wdata), .cpsr(cpsr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d);
    wr_en[p]   = 1'b1;
    wr_addr[p] = a;
    wr_data[p] = d;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    pc_stall = 1'b1; pc_we = 1'b0; pc_wdata = '0;
    cpsr_we = 1'b0; cpsr_be = '0; cpsr_wdata = '0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_cpsr", cpsr, 32'h0);
    chk("rst_rd0", rd_data[0], 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #4;  // now 1 time unit before... realign to post-edge sampling
    step();

    // PC increment, stall, branch, wrap
    pc_stall = 1'b0;
    chk("pc_0", pc, 32'h0);
    step(); chk("pc_4", pc, 32'h4);
    step(); chk("pc_8", pc, 32'h8);
    step(); chk("pc_12", pc, 32'hC);
    pc_stall = 1'b1;
    step(); chk("pc_hold1", pc, 32'hC);
    step(); chk("pc_hold2", pc, 32'hC);
    pc_we = 1'b1; pc_wdata = 32'h100;
    step(); chk("pc_branch", pc, 32'h100);
    pc_wdata = 32'hFFFF_FFFC;
    step(); chk("pc_preload", pc, 32'hFFFF_FFFC);
    pc_we = 1'b0; pc_stall = 1'b0;
    step(); chk("pc_wrap", pc, 32'h0);
    pc_stall = 1'b1;

    // Write-port collision and distinct-address dual write
    wr(0, 4'd3, 32'hAAAA); wr(1, 4'd3, 32'h5555);
    step();
    wr(0, 4'd1, 32'h11); wr(1, 4'd2, 32'h22);
    step();
    wr_en = '0;
    rd_addr[0] = 4'd3; rd_addr[1] = 4'd1; rd_addr[2] = 4'd2; rd_addr[3] = 4'd3;
    step();
    chk("coll_r3_p0", rd_data[0], 32'h5555);
    chk("dual_r1", rd_data[1], 32'h11);
    chk("dual_r2", rd_data[2], 32'h22);
    chk("coll_r3_p3", rd_data[3], 32'h5555);

    // Read latency / forwarding
    rd_addr[0] = 4'd5;
    wr(0, 4'd5, 32'h1234);
    step();
`ifdef RF_BYPASS_EN
    chk("byp_r5", rd_data[0], 32'h1234);
`else
    chk("old_r5", rd_data[0], 32'h0);
`endif
    wr_en = '0;
    step(); chk("r5_next", rd_data[0], 32'h1234);

    // PC priority: pc_we over port, port over increment
    pc_we = 1'b1; pc_wdata = 32'h200; wr(0, 4'd15, 32'h300);
    step(); chk("pcpri_we", pc, 32'h200);
    pc_we = 1'b0;
    rd_addr[1] = 4'd15;
    step(); chk("pcpri_port", pc, 32'h300);
`ifdef RF_BYPASS_EN
    chk("rd_pc_byp", rd_data[1], 32'h300);
`else
    chk("rd_pc_old", rd_data[1], 32'h200);
`endif
    pc_stall = 1'b0; wr(0, 4'd15, 32'h400);
    step(); chk("pcpri_inc", pc, 32'h400);
    wr_en = '0; pc_stall = 1'b1;

    // CPSR byte enables
    chk("cpsr_init", cpsr, 32'h0);
    cpsr_we = 1'b1; cpsr_be = 4'b1000; cpsr_wdata = 32'hF0FF_FFFF;
    step(); chk("cpsr_flags", cpsr, 32'hF000_0000);
    cpsr_be = 4'b0000; cpsr_wdata = 32'hFFFF_FFFF;
    step(); chk("cpsr_be0", cpsr, 32'hF000_0000);
    cpsr_be = 4'b0001; cpsr_wdata = 32'h1234_5678;
    step(); chk("cpsr_b0", cpsr, 32'hF000_0078);
    cpsr_we = 1'b0; cpsr_be = 4'b1111; cpsr_wdata = 32'h0;
    step(); chk("cpsr_nowe", cpsr, 32'hF000_0078);

    // Async reset mid-cycle, with a write pending across the reset edge
    rd_addr[0] = 4'd5;
    step(); chk("pre_rst_r5", rd_data[0], 32'h1234);
    wr(0, 4'd6, 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_cpsr", cpsr, 32'h0);
    chk("arst_rd0", rd_data[0], 32'h0);
    step();
    wr_en = '0;
    rst_n = 1'b1;
    rd_addr[0] = 4'd5; rd_addr[1] = 4'd6;
    step();
    chk("post_rst_r5", rd_data[0], 32'h0);
    chk("post_rst_r6", rd_data[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
